// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Brief    : Request/response and Memory port bundle for mem_access_unit.
//  Revision : 1.0
// ============================================================================
interface mem_access_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspErr;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteEnable;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData,
        input  rspReady, memReadData,
        output reqReady, rspValid, rspData, rspErr,
        output memAddress, memWriteData, memWriteEnable
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData,
        output rspReady, memReadData,
        input  reqReady, rspValid, rspData, rspErr,
        input  memAddress, memWriteData, memWriteEnable
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : Single-outstanding load/store initiator with sub-word RMW stores.
//  Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_SHIFT = 0
) (
    input  wire logic        Clk,
    input  wire logic        Rst_n,
    mem_access_unit_if.slave bus
);
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_READ    = 3'd1;
    localparam logic [2:0] c_RMW_RD  = 3'd2;
    localparam logic [2:0] c_WRITE   = 3'd3;
    localparam logic [2:0] c_RESP    = 3'd4;
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [2:0]  r_state, w_state_nxt;
    logic [31:0] r_word_idx, r_wdata, r_merge, r_rsp_data;
    logic [1:0]  r_lane, r_size;
    logic        r_signed, r_rsp_err;
    logic [31:0] w_req_idx;
    logic [1:0]  w_req_lane;
    logic        w_accept, w_req_err;
    logic [4:0]  w_shamt;
    logic [31:0] w_rd_shifted, w_load_val, w_lane_mask, w_merged;

    generate
        if (ADDR_SHIFT == 2) begin : g_lane_shift2
            assign w_req_idx  = {2'b00, bus.reqAddr[31:2]};
            assign w_req_lane = bus.reqAddr[1:0];
        end else begin : g_lane_shift0
            assign w_req_idx  = bus.reqAddr;
            assign w_req_lane = 2'b00;
        end
    endgenerate

    assign w_accept = bus.reqValid && (r_state == c_IDLE);

    always_comb begin
        w_req_err = 1'b0;
        case (bus.reqSize)
            c_SZ_BYTE: w_req_err = 1'b0;
            c_SZ_HALF: w_req_err = w_req_lane[0];
            c_SZ_WORD: w_req_err = (w_req_lane != 2'b00);
            default:   w_req_err = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)                   w_state_nxt = c_RESP;
                    else if (!bus.reqWrite)          w_state_nxt = c_READ;
                    else if (bus.reqSize == c_SZ_WORD) w_state_nxt = c_WRITE;
                    else                             w_state_nxt = c_RMW_RD;
                end
            end
            c_READ:   w_state_nxt = c_RESP;
            c_RMW_RD: w_state_nxt = c_WRITE;
            c_WRITE:  w_state_nxt = c_RESP;
            c_RESP:   if (bus.rspReady) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Lane position in bits; the same shift serves load extraction and store merge.
    assign w_shamt      = {r_lane, 3'b000};
    assign w_rd_shifted = bus.memReadData >> w_shamt;

    always_comb begin
        w_load_val = w_rd_shifted;
        case (r_size)
            c_SZ_BYTE: w_load_val = {{24{r_signed & w_rd_shifted[7]}},  w_rd_shifted[7:0]};
            c_SZ_HALF: w_load_val = {{16{r_signed & w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            default:   w_load_val = w_rd_shifted;
        endcase
    end

    always_comb begin
        w_lane_mask = (r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        w_merged    = (r_merge & ~(w_lane_mask << w_shamt)) | ((r_wdata & w_lane_mask) << w_shamt);
    end

    always_comb begin
        bus.reqReady       = 1'b0;
        bus.rspValid       = 1'b0;
        bus.memWriteEnable = 1'b0;
        bus.memWriteData   = 32'h0;
        case (r_state)
            c_IDLE:  bus.reqReady = 1'b1;
            c_WRITE: begin
                bus.memWriteEnable = 1'b1;
                bus.memWriteData   = (r_size == c_SZ_WORD) ? r_wdata : w_merged;
            end
            c_RESP:  bus.rspValid = 1'b1;
            default: ;
        endcase
    end

    assign bus.memAddress = r_word_idx;
    assign bus.rspData    = r_rsp_data;
    assign bus.rspErr     = r_rsp_err;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_word_idx <= 32'h0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_wdata    <= 32'h0;
            r_merge    <= 32'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            // Clearing the response here leaves 0 for stores and errors.
            if (w_accept) begin
                r_word_idx <= w_req_idx;
                r_lane     <= w_req_lane;
                r_size     <= bus.reqSize;
                r_signed   <= bus.reqSigned;
                r_wdata    <= bus.reqWData;
                r_rsp_data <= 32'h0;
                r_rsp_err  <= w_req_err;
            end
            if (r_state == c_READ) begin
                r_rsp_data <= w_load_val;
            end
            if (r_state == c_RMW_RD) begin
                r_merge <= bus.memReadData;
            end
        end
    end
endmodule
`default_nettype wire
